// File: rtl/alu_acc.sv
// alu_acc: small ALU with an iterative shift-add multiplier and a MAC
// accumulator behind valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation presented on sel/a/b
//   in_ready   block is idle and can accept an operation
//   sel        opcode: ADD SUB MUL AND OR XOR MAC CLR
//   a, b       unsigned W-bit operands
//   out_valid  result held on out/ovf
//   out_ready  consumer takes the result
//   out        registered 2W-bit result
//   ovf        MAC accumulator wrapped (valid with out_valid)

module alu_acc #(
   parameter int W   = 4,
   parameter int OPW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] sel,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out,
   output logic           ovf
);

   localparam int CW = $clog2(W + 1);

   localparam logic [OPW-1:0] OP_ADD = 3'b000;
   localparam logic [OPW-1:0] OP_SUB = 3'b001;
   localparam logic [OPW-1:0] OP_MUL = 3'b010;
   localparam logic [OPW-1:0] OP_AND = 3'b011;
   localparam logic [OPW-1:0] OP_OR  = 3'b100;
   localparam logic [OPW-1:0] OP_XOR = 3'b101;
   localparam logic [OPW-1:0] OP_MAC = 3'b110;
   localparam logic [OPW-1:0] OP_CLR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [2*W-1:0]   out_q, out_d;
   logic             ovf_q, ovf_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplr_q, mplr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [2*W-1:0]   a_x, b_x;
   logic [2*W-1:0]   step;
   logic [2*W:0]     mac;
   logic [2*W-1:0]   alu;
   logic             is_mul;

   assign a_x = {{W{1'b0}}, a};
   assign b_x = {{W{1'b0}}, b};

   // Single-cycle result, evaluated from the operands at the accept edge.
   always_comb begin
      alu = '0;
      unique case (1'b1)
         (sel == OP_ADD): alu = a_x + b_x;
         (sel == OP_SUB): alu = a_x - b_x;
         (sel == OP_AND): alu = a_x & b_x;
         (sel == OP_OR):  alu = a_x | b_x;
         (sel == OP_XOR): alu = a_x ^ b_x;
         default:         alu = '0;
      endcase
   end

   assign is_mul = (sel == OP_MUL) || (sel == OP_MAC);

   // One multiplier bit per cycle; the last step's sum is the product.
   assign step = prod_q + (mplr_q[0] ? mcand_q : '0);
   assign mac  = {1'b0, acc_q} + {1'b0, step};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d = sel;
               if (is_mul) begin
                  state_d = MUL;
                  prod_d  = '0;
                  mcand_d = a_x;
                  mplr_d  = b;
                  cnt_d   = '0;
               end else begin
                  state_d = DONE;
                  out_d   = alu;
                  ovf_d   = 1'b0;
                  if (sel == OP_CLR) begin
                     acc_d = '0;
                  end
               end
            end
         end
         MUL: begin
            prod_d  = step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
               if (op_q == OP_MAC) begin
                  out_d = mac[2*W-1:0];
                  ovf_d = mac[2*W];
                  acc_d = mac[2*W-1:0];
               end else begin
                  out_d = step;
                  ovf_d = 1'b0;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         acc_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed tests for alu_acc at W = 4.
// Expected values are hand-computed constants.

module tb_alu_acc;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   sel;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [2*W-1:0] out;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   alu_acc #(.W(W), .OPW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Accept one op and step to the edge where its result appears.
   task automatic do_op(input logic [2:0] s, input logic [3:0] x,
                        input logic [3:0] y);
      in_valid = 1'b1;
      sel = s;
      a = x;
      b = y;
      cyc();
      in_valid = 1'b0;
      if (s == 3'b010 || s == 3'b110) repeat (W) cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      checks++;
      if (out !== 8'h00 || out_valid !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs: out=%h v=%b ovf=%b want 00 0 0",
                  out, out_valid, ovf);
      end
      cyc();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_add();
      do_op(3'b000, 4'd2, 4'd3);
      checks++;
      if (out_valid !== 1'b1 || out !== 8'h05 || ovf !== 1'b0 ||
          in_ready !== 1'b0) begin
         errors++;
         $display("FAIL add: v=%b out=%h ovf=%b rdy=%b want 1 05 0 0",
                  out_valid, out, ovf, in_ready);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h05) begin
         errors++;
         $display("FAIL add_drain: v=%b rdy=%b out=%h want 0 1 05",
                  out_valid, in_ready, out);
      end
   endtask

   task automatic test_logic();
      logic [2:0] ts [6] = '{3'b001, 3'b011, 3'b101, 3'b100, 3'b000, 3'b001};
      logic [3:0] ta [6] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd15, 4'd9};
      logic [3:0] tb [6] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd15, 4'd4};
      logic [7:0] te [6] = '{8'hFF, 8'h02, 8'h01, 8'h03, 8'h1E, 8'h05};
      for (int i = 0; i < 6; i++) begin
         do_op(ts[i], ta[i], tb[i]);
         checks++;
         if (out_valid !== 1'b1 || out !== te[i] || ovf !== 1'b0) begin
            errors++;
            $display("FAIL logic[%0d]: v=%b out=%h ovf=%b want 1 %h 0",
                     i, out_valid, out, ovf, te[i]);
         end
         cyc();
      end
   endtask

   task automatic test_mul();
      logic [3:0] ta [3] = '{4'd15, 4'd13, 4'd0};
      logic [3:0] tb [3] = '{4'd15, 4'd11, 4'd9};
      logic [7:0] te [3] = '{8'hE1, 8'h8F, 8'h00};
      logic [7:0] prev;
      for (int i = 0; i < 3; i++) begin
         prev = out;
         in_valid = 1'b1;
         sel = 3'b010;
         a = ta[i];
         b = tb[i];
         cyc();
         in_valid = 1'b0;
         for (int k = 0; k < W; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out !== prev) begin
               errors++;
               $display("FAIL mul_busy[%0d.%0d]: rdy=%b v=%b out=%h want 0 0 %h",
                        i, k, in_ready, out_valid, out, prev);
            end
            cyc();
         end
         checks++;
         if (out_valid !== 1'b1 || out !== te[i] || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mul[%0d]: v=%b out=%h ovf=%b want 1 %h 0",
                     i, out_valid, out, ovf, te[i]);
         end
         cyc();
      end
   endtask

   task automatic test_mac();
      do_op(3'b111, 4'd0, 4'd0);
      checks++;
      if (out !== 8'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL clr0: out=%h ovf=%b want 00 0", out, ovf);
      end
      cyc();
      do_op(3'b110, 4'd15, 4'd15);
      checks++;
      if (out_valid !== 1'b1 || out !== 8'hE1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mac1: v=%b out=%h ovf=%b want 1 E1 0",
                  out_valid, out, ovf);
      end
      cyc();
      do_op(3'b110, 4'd15, 4'd15);
      checks++;
      if (out_valid !== 1'b1 || out !== 8'hC2 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL mac2: v=%b out=%h ovf=%b want 1 C2 1",
                  out_valid, out, ovf);
      end
      cyc();
      do_op(3'b111, 4'd5, 4'd5);
      checks++;
      if (out !== 8'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL clr1: out=%h ovf=%b want 00 0", out, ovf);
      end
      cyc();
      do_op(3'b110, 4'd3, 4'd2);
      checks++;
      if (out !== 8'h06 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mac_after_clr: out=%h ovf=%b want 06 0", out, ovf);
      end
      cyc();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      do_op(3'b000, 4'd2, 4'd3);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out !== 8'h05 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d]: v=%b out=%h rdy=%b want 1 05 0",
                     i, out_valid, out, in_ready);
         end
         in_valid = (i % 2 == 0);
         sel = 3'b010;
         a = 4'd7;
         b = 4'd7;
         cyc();
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out !== 8'h05) begin
         errors++;
         $display("FAIL stall_end: v=%b out=%h want 1 05", out_valid, out);
      end
      out_ready = 1'b1;
      cyc();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h05) begin
         errors++;
         $display("FAIL stall_release: v=%b rdy=%b out=%h want 0 1 05",
                  out_valid, in_ready, out);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      sel = 3'b000;
      a = 4'd1;
      b = 4'd1;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out !== 8'h02) begin
         errors++;
         $display("FAIL b2b_first: v=%b out=%h want 1 02", out_valid, out);
      end
      a = 4'd4;
      b = 4'd4;
      cyc();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h02) begin
         errors++;
         $display("FAIL b2b_gap: v=%b rdy=%b out=%h want 0 1 02",
                  out_valid, in_ready, out);
      end
      cyc();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out !== 8'h08) begin
         errors++;
         $display("FAIL b2b_second: v=%b out=%h want 1 08", out_valid, out);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      do_op(3'b110, 4'd15, 4'd15);
      cyc();
      in_valid = 1'b1;
      sel = 3'b110;
      a = 4'd3;
      b = 4'd3;
      cyc();
      in_valid = 1'b0;
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      checks++;
      if (out !== 8'h00 || out_valid !== 1'b0 || ovf !== 1'b0 ||
          in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: out=%h v=%b ovf=%b rdy=%b want 00 0 0 1",
                  out, out_valid, ovf, in_ready);
      end
      do_op(3'b000, 4'd2, 4'd3);
      checks++;
      if (out_valid !== 1'b1 || out !== 8'h05) begin
         errors++;
         $display("FAIL rst_add: v=%b out=%h want 1 05", out_valid, out);
      end
      cyc();
      do_op(3'b110, 4'd1, 4'd1);
      checks++;
      if (out !== 8'h01 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL rst_acc: out=%h ovf=%b want 01 0", out, ovf);
      end
      cyc();
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      sel = 3'b000;
      a = '0;
      b = '0;
      #1;
      test_reset();
      test_add();
      test_logic();
      test_mul();
      test_mac();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
